assoc_cache: RTL and testbench

Parametrised N-way set-associative, read-only, line-fill cache between the processor-side bus and the DRAM-side bus. It generalises the 2-way line cache to configurable sets, ways, line size and bus width. It adds true-LRU replacement across any way count, critical-word-first response ordering, and a whole-cache flush. Misses fetch one full line from memory as a burst; every request, hit or miss, returns the full line to the processor as a burst.

---
 rtl/assoc_cache_if.sv | 40 ++++
 rtl/assoc_cache.sv | 263 ++++++++++++++++++++++++++
 tb/tb_assoc_cache.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/assoc_cache_if.sv
// Processor-side and memory-side bus bundle for assoc_cache.
// The cache connects through the slave modport; the requester/memory
// environment connects through the master modport.
interface assoc_cache_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
);
  // processor side
  logic                      p_bus_reqcyc;
  logic                      p_bus_reqack;
  logic [BUS_DATA_WIDTH-1:0] p_bus_req;
  logic [BUS_TAG_WIDTH-1:0]  p_bus_reqtag;
  logic                      p_bus_respcyc;
  logic                      p_bus_respack;
  logic [BUS_DATA_WIDTH-1:0] p_bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  p_bus_resptag;
  // memory side
  logic                      m_bus_reqcyc;
  logic                      m_bus_reqack;
  logic [BUS_DATA_WIDTH-1:0] m_bus_req;
  logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag;
  logic                      m_bus_respcyc;
  logic                      m_bus_respack;
  logic [BUS_DATA_WIDTH-1:0] m_bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag;

  modport slave (
    input  p_bus_reqcyc, p_bus_req, p_bus_reqtag, p_bus_respack,
    input  m_bus_reqack, m_bus_respcyc, m_bus_resp, m_bus_resptag,
    output p_bus_reqack, p_bus_respcyc, p_bus_resp, p_bus_resptag,
    output m_bus_reqcyc, m_bus_req, m_bus_reqtag, m_bus_respack
  );

  modport master (
    output p_bus_reqcyc, p_bus_req, p_bus_reqtag, p_bus_respack,
    output m_bus_reqack, m_bus_respcyc, m_bus_resp, m_bus_resptag,
    input  p_bus_reqack, p_bus_respcyc, p_bus_resp, p_bus_resptag,
    input  m_bus_reqcyc, m_bus_req, m_bus_reqtag, m_bus_respack
  );
endinterface

// File: rtl/assoc_cache.sv
// N-way set-associative read-only line cache with true-LRU replacement,
// critical-word-first line bursts to the processor and a one-cycle flush.
// Tags and line data live in per-way block RAMs read during ACK so the
// registered read data is ready for the tag compare in LOOKUP.
module assoc_cache #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int ADDR_WIDTH     = 64,
  parameter int NUM_SETS       = 16,
  parameter int NUM_WAYS       = 4,
  parameter int LINE_BYTES     = 64,
  parameter int CRITICAL_FIRST = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  assoc_cache_if.slave bus
);
  localparam int BEATS   = LINE_BYTES * 8 / BUS_DATA_WIDTH;
  localparam int OFF_W   = $clog2(LINE_BYTES);
  localparam int IDX_W   = $clog2(NUM_SETS);
  localparam int TAG_W   = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int BEAT_LO = $clog2(BUS_DATA_WIDTH / 8);
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int AGE_W   = WAY_W;
  localparam int LINE_W  = LINE_BYTES * 8;

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_ACK, S_LOOKUP, S_MREQ, S_MFILL, S_UPDATE, S_RESP
  } state_t;

  typedef logic [NUM_WAYS-1:0][AGE_W-1:0] age_vec_t;

  state_t                    state_reg;
  logic [ADDR_WIDTH-1:0]     addr_reg;
  logic [BUS_TAG_WIDTH-1:0]  tag_reg;
  logic [BEAT_W-1:0]         beat_cnt_reg;
  logic [LINE_W-1:0]         line_buf_reg;
  logic [WAY_W-1:0]          victim_reg;
  logic                      reqack_reg;
  logic                      respcyc_reg;
  logic [BUS_DATA_WIDTH-1:0] resp_reg;
  logic [BUS_TAG_WIDTH-1:0]  resptag_reg;
  logic                      m_reqcyc_reg;
  logic [BUS_DATA_WIDTH-1:0] m_req_reg;
  logic [BUS_TAG_WIDTH-1:0]  m_reqtag_reg;

  logic [NUM_WAYS-1:0]       valid_reg [NUM_SETS];
  age_vec_t                  age_reg   [NUM_SETS];

  logic [IDX_W-1:0]          cur_idx;
  logic [TAG_W-1:0]          cur_tag;
  logic [BEAT_W-1:0]         start_beat;
  logic [NUM_WAYS-1:0]       set_valid;
  age_vec_t                  set_age;
  logic [NUM_WAYS-1:0]       way_hit;
  logic [NUM_WAYS-1:0][LINE_W-1:0] way_line;
  logic                      hit_any;
  logic [WAY_W-1:0]          hit_way;
  logic [WAY_W-1:0]          victim_way;
  logic                      unused_resptag;

  assign cur_idx    = addr_reg[IDX_W+OFF_W-1:OFF_W];
  assign cur_tag    = addr_reg[ADDR_WIDTH-1:IDX_W+OFF_W];
  assign start_beat = BEAT_W'((addr_reg[OFF_W-1:0] >> BEAT_LO) & OFF_W'(BEATS - 1));
  assign set_valid  = valid_reg[cur_idx];
  assign set_age    = age_reg[cur_idx];
  assign unused_resptag = ^bus.m_bus_resptag;

  // Which line beat goes out as the k-th processor beat.
  function automatic logic [BEAT_W-1:0] beat_sel(input logic [BEAT_W-1:0] start,
                                                 input logic [BEAT_W-1:0] k);
    logic [BEAT_W-1:0] s;
    s = (CRITICAL_FIRST != 0) ? BEAT_W'(start + k) : k;
    return (BEATS == 1) ? '0 : s;
  endfunction

  function automatic logic [BUS_DATA_WIDTH-1:0] beat_of(input logic [LINE_W-1:0] line,
                                                        input logic [BEAT_W-1:0] b);
    return line[b*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
  endfunction

  // Way v becomes most recent; younger ways age by one, older ones keep their age.
  function automatic age_vec_t touch_ages(input age_vec_t ages, input logic [WAY_W-1:0] v);
    age_vec_t res;
    res = ages;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (WAY_W'(w) == v)
        res[w] = '0;
      else if (ages[w] < ages[v])
        res[w] = ages[w] + 1'b1;
    end
    return res;
  endfunction

  function automatic age_vec_t initial_ages();
    age_vec_t res;
    for (int w = 0; w < NUM_WAYS; w++)
      res[w] = AGE_W'(w);
    return res;
  endfunction

  // Per-way tag and data RAMs: written in UPDATE, read (registered) in ACK.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
      logic [TAG_W-1:0]  tag_mem  [NUM_SETS];
      logic [LINE_W-1:0] data_mem [NUM_SETS];
      logic [TAG_W-1:0]  tag_rd_reg;
      logic [LINE_W-1:0] line_rd_reg;

      // RAM write of a filled line and registered read for the lookup
      always_ff @(posedge clk) begin
        if (state_reg == S_UPDATE && victim_reg == WAY_W'(gi)) begin
          tag_mem[cur_idx]  <= cur_tag;
          data_mem[cur_idx] <= line_buf_reg;
        end
        if (state_reg == S_ACK) begin
          tag_rd_reg  <= tag_mem[cur_idx];
          line_rd_reg <= data_mem[cur_idx];
        end
      end

      assign way_hit[gi]  = set_valid[gi] && (tag_rd_reg == cur_tag);
      assign way_line[gi] = line_rd_reg;
    end
  endgenerate

  // Hit encoding and victim choice (lowest invalid way, else the oldest way)
  always_comb begin
    hit_any    = 1'b0;
    hit_way    = '0;
    victim_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (set_age[w] == AGE_W'(NUM_WAYS - 1))
        victim_way = WAY_W'(w);
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!set_valid[w])
        victim_way = WAY_W'(w);
    end
  end

  // Main controller with registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      tag_reg      <= '0;
      beat_cnt_reg <= '0;
      line_buf_reg <= '0;
      victim_reg   <= '0;
      reqack_reg   <= 1'b0;
      respcyc_reg  <= 1'b0;
      resp_reg     <= '0;
      resptag_reg  <= '0;
      m_reqcyc_reg <= 1'b0;
      m_req_reg    <= '0;
      m_reqtag_reg <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_reg[s] <= '0;
        age_reg[s]   <= initial_ages();
      end
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (flush) begin
            state_reg <= S_FLUSH;
          end else if (bus.p_bus_reqcyc) begin
            addr_reg   <= bus.p_bus_req[ADDR_WIDTH-1:0];
            tag_reg    <= bus.p_bus_reqtag;
            reqack_reg <= 1'b1;
            state_reg  <= S_ACK;
          end
        end
        S_FLUSH: begin
          for (int s = 0; s < NUM_SETS; s++) begin
            valid_reg[s] <= '0;
            age_reg[s]   <= initial_ages();
          end
          state_reg <= S_IDLE;
        end
        S_ACK: begin
          reqack_reg <= 1'b0;
          state_reg  <= S_LOOKUP;
        end
        S_LOOKUP: begin
          beat_cnt_reg <= '0;
          if (hit_any) begin
            line_buf_reg     <= way_line[hit_way];
            resp_reg         <= beat_of(way_line[hit_way], beat_sel(start_beat, '0));
            resptag_reg      <= tag_reg;
            respcyc_reg      <= 1'b1;
            age_reg[cur_idx] <= touch_ages(set_age, hit_way);
            state_reg        <= S_RESP;
          end else begin
            victim_reg   <= victim_way;
            m_reqcyc_reg <= 1'b1;
            m_req_reg    <= BUS_DATA_WIDTH'({addr_reg[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}});
            m_reqtag_reg <= tag_reg;
            state_reg    <= S_MREQ;
          end
        end
        S_MREQ: begin
          if (bus.m_bus_reqack) begin
            m_reqcyc_reg <= 1'b0;
            state_reg    <= S_MFILL;
          end
        end
        S_MFILL: begin
          if (bus.m_bus_respcyc) begin
            line_buf_reg[beat_cnt_reg*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= bus.m_bus_resp;
            if (beat_cnt_reg == BEAT_W'(BEATS - 1)) begin
              beat_cnt_reg <= '0;
              state_reg    <= S_UPDATE;
            end else begin
              beat_cnt_reg <= BEAT_W'(beat_cnt_reg + 1'b1);
            end
          end
        end
        S_UPDATE: begin
          valid_reg[cur_idx][victim_reg] <= 1'b1;
          age_reg[cur_idx] <= touch_ages(set_age, victim_reg);
          resp_reg         <= beat_of(line_buf_reg, beat_sel(start_beat, '0));
          resptag_reg      <= tag_reg;
          respcyc_reg      <= 1'b1;
          state_reg        <= S_RESP;
        end
        S_RESP: begin
          if (bus.p_bus_respack) begin
            if (beat_cnt_reg == BEAT_W'(BEATS - 1)) begin
              beat_cnt_reg <= '0;
              respcyc_reg  <= 1'b0;
              resp_reg     <= '0;
              state_reg    <= S_IDLE;
            end else begin
              beat_cnt_reg <= BEAT_W'(beat_cnt_reg + 1'b1);
              resp_reg     <= beat_of(line_buf_reg,
                                      beat_sel(start_beat, BEAT_W'(beat_cnt_reg + 1'b1)));
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.p_bus_reqack  = reqack_reg;
  assign bus.p_bus_respcyc = respcyc_reg;
  assign bus.p_bus_resp    = resp_reg;
  assign bus.p_bus_resptag = resptag_reg;
  assign bus.m_bus_reqcyc  = m_reqcyc_reg;
  assign bus.m_bus_req     = m_req_reg;
  assign bus.m_bus_reqtag  = m_reqtag_reg;
  assign bus.m_bus_respack = (state_reg == S_MFILL) && bus.m_bus_respcyc;
endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache: a scoreboard queue holds expected processor
// beats and expected memory line requests; a memory model answers fills.
module tb_assoc_cache;
  localparam int DW    = 64;
  localparam int TW    = 13;
  localparam int BEATS = 8;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  assoc_cache_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bus ();

  assoc_cache #(
    .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .ADDR_WIDTH(64), .NUM_SETS(16),
    .NUM_WAYS(4), .LINE_BYTES(64), .CRITICAL_FIRST(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int mreq_count = 0;
  int mem_drv_beat = -1;

  logic [63:0]   exp_data_q [$];
  logic [TW-1:0] exp_tag_q  [$];
  logic [63:0]   mem_addr_q [$];
  logic [TW-1:0] mem_tag_q  [$];

  function automatic logic [63:0] mem_word(input logic [63:0] line, input int b);
    return ((line - 64'h1000_0040) << 4) + 64'h10 + 64'(b);
  endfunction

  function automatic logic [63:0] set2_addr(input logic [63:0] t);
    return (t << 10) | 64'h80;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Memory model: accepts a line request, then streams 8 beats back to back
  initial begin
    bit active;
    logic [63:0] line;
    int b;
    active = 0;
    line = '0;
    b = 0;
    bus.m_bus_reqack  = 1'b0;
    bus.m_bus_respcyc = 1'b0;
    bus.m_bus_resp    = '0;
    bus.m_bus_resptag = '0;
    forever begin
      @(negedge clk);
      bus.m_bus_reqack  = 1'b0;
      bus.m_bus_respcyc = 1'b0;
      mem_drv_beat = -1;
      if (reset) begin
        active = 0;
      end else if (active) begin
        bus.m_bus_respcyc = 1'b1;
        bus.m_bus_resp    = mem_word(line, b);
        mem_drv_beat = b;
        #1 check("m_respack", 64'(bus.m_bus_respack), 64'd1);
        b++;
        if (b == BEATS) active = 0;
      end else if (bus.m_bus_reqcyc) begin
        mreq_count++;
        check("mreq_expected", 64'(mem_addr_q.size() > 0), 64'd1);
        if (mem_addr_q.size() > 0) begin
          check("m_req_addr", bus.m_bus_req, mem_addr_q.pop_front());
          check("m_req_tag", 64'(bus.m_bus_reqtag), 64'(mem_tag_q.pop_front()));
        end
        $display("MEM line request addr=%h tag=%h", bus.m_bus_req, bus.m_bus_reqtag);
        line = bus.m_bus_req;
        bus.m_bus_reqack = 1'b1;
        active = 1;
        b = 0;
      end
    end
  end

  task automatic check_outputs_zero(input string name);
    check({name, "_reqack"},  64'(bus.p_bus_reqack), 64'd0);
    check({name, "_respcyc"}, 64'(bus.p_bus_respcyc), 64'd0);
    check({name, "_resp"},    bus.p_bus_resp, 64'd0);
    check({name, "_resptag"}, 64'(bus.p_bus_resptag), 64'd0);
    check({name, "_mreqcyc"}, 64'(bus.m_bus_reqcyc), 64'd0);
    check({name, "_mreq"},    bus.m_bus_req, 64'd0);
    check({name, "_mreqtag"}, 64'(bus.m_bus_reqtag), 64'd0);
    check({name, "_mrespack"}, 64'(bus.m_bus_respack), 64'd0);
  endtask

  // One processor read: pushes expectations, drives the request, collects 8 beats.
  task automatic do_req(input string name, input logic [63:0] addr, input logic [TW-1:0] tag,
                        input bit exp_miss, input int exp_ack_cyc, input int exp_first,
                        input int stall_beat, input int flush_cycles);
    logic [63:0] line;
    int start, m0, cyc, acks, ack_cyc, first, got, stall_left;
    line  = {addr[63:6], 6'b0};
    start = int'(addr[5:3]);
    m0 = mreq_count;
    cyc = 0; acks = 0; ack_cyc = -1; first = -1; got = 0; stall_left = 5;
    for (int k = 0; k < BEATS; k++) begin
      exp_data_q.push_back(mem_word(line, (start + k) % BEATS));
      exp_tag_q.push_back(tag);
    end
    if (exp_miss) begin
      mem_addr_q.push_back(line);
      mem_tag_q.push_back(tag);
    end
    bus.p_bus_req    = addr;
    bus.p_bus_reqtag = tag;
    bus.p_bus_reqcyc = 1'b1;
    if (flush_cycles > 0) flush = 1'b1;
    while (got < BEATS && cyc < 300) begin
      @(negedge clk);
      cyc++;
      bus.p_bus_respack = 1'b0;
      if (cyc == flush_cycles) flush = 1'b0;
      if (bus.p_bus_reqack) begin
        acks++;
        if (ack_cyc < 0) ack_cyc = cyc;
        bus.p_bus_reqcyc = 1'b0;
      end
      if (bus.p_bus_respcyc && exp_data_q.size() > 0) begin
        if (first < 0) first = cyc;
        check({name, "_data"}, bus.p_bus_resp, exp_data_q[0]);
        check({name, "_tag"}, 64'(bus.p_bus_resptag), 64'(exp_tag_q[0]));
        if (got == stall_beat && stall_left > 0) begin
          stall_left--;
        end else begin
          void'(exp_data_q.pop_front());
          void'(exp_tag_q.pop_front());
          bus.p_bus_respack = 1'b1;
          got++;
        end
      end
    end
    @(negedge clk);
    bus.p_bus_respack = 1'b0;
    bus.p_bus_reqcyc  = 1'b0;
    flush = 1'b0;
    check({name, "_beats"}, 64'(got), 64'(BEATS));
    check({name, "_resp_done"}, 64'(bus.p_bus_respcyc), 64'd0);
    check({name, "_ack_cycle"}, 64'(ack_cyc), 64'(exp_ack_cyc));
    check({name, "_ack_pulses"}, 64'(acks), 64'd1);
    check({name, "_mem_reqs"}, 64'(mreq_count - m0), 64'(exp_miss));
    if (exp_first >= 0) check({name, "_first_resp"}, 64'(first), 64'(exp_first));
    exp_data_q.delete();
    exp_tag_q.delete();
    mem_addr_q.delete();
    mem_tag_q.delete();
    $display("REQ %s addr=%h tag=%h miss=%0d beats=%0d ack_cyc=%0d first=%0d",
             name, addr, tag, exp_miss, got, ack_cyc, first);
  endtask

  initial begin
    int cyc;
    bit found;
    reset = 1'b1;
    flush = 1'b0;
    bus.p_bus_reqcyc  = 1'b0;
    bus.p_bus_req     = '0;
    bus.p_bus_reqtag  = '0;
    bus.p_bus_respack = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    $display("RESET outputs checked");
    reset = 1'b0;
    @(negedge clk);

    do_req("cold_miss", 64'h1000_0048, 13'h5, 1'b1, 1, -1, -1, 0);
    do_req("hit", 64'h1000_0040, 13'h6, 1'b0, 1, 3, -1, 0);
    do_req("backpressure", 64'h1000_0048, 13'h7, 1'b0, 1, 3, 3, 0);

    do_req("lru_fill_a", set2_addr(64'h100), 13'h11, 1'b1, 1, -1, -1, 0);
    do_req("lru_fill_b", set2_addr(64'h101), 13'h12, 1'b1, 1, -1, -1, 0);
    do_req("lru_fill_c", set2_addr(64'h102), 13'h13, 1'b1, 1, -1, -1, 0);
    do_req("lru_fill_d", set2_addr(64'h103), 13'h14, 1'b1, 1, -1, -1, 0);
    do_req("lru_hit_a",  set2_addr(64'h100), 13'h15, 1'b0, 1, 3, -1, 0);
    do_req("lru_miss_e", set2_addr(64'h104), 13'h16, 1'b1, 1, -1, -1, 0);
    do_req("lru_rehit_a", set2_addr(64'h100), 13'h17, 1'b0, 1, 3, -1, 0);
    do_req("lru_evicted_b", set2_addr(64'h101), 13'h18, 1'b1, 1, -1, -1, 0);

    do_req("flush_req", set2_addr(64'h100), 13'h19, 1'b1, 3, -1, -1, 1);

    // Reset while the fill is streaming beat 4
    mem_addr_q.push_back(64'h1000_0040);
    mem_tag_q.push_back(13'h9);
    bus.p_bus_req    = 64'h1000_0048;
    bus.p_bus_reqtag = 13'h9;
    bus.p_bus_reqcyc = 1'b1;
    cyc = 0;
    found = 0;
    while (!found && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.p_bus_reqack) found = 1;
    end
    bus.p_bus_reqcyc = 1'b0;
    check("rst_fill_ack", 64'(found), 64'd1);
    cyc = 0;
    found = 0;
    while (!found && cyc < 50) begin
      @(negedge clk);
      #2;
      cyc++;
      if (mem_drv_beat == 4) found = 1;
    end
    check("rst_fill_beat4", 64'(found), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_outputs_zero("mid_reset");
    $display("RESET during fill, outputs checked");
    @(negedge clk);
    reset = 1'b0;
    mem_addr_q.delete();
    mem_tag_q.delete();
    @(negedge clk);
    do_req("after_reset", 64'h1000_0048, 13'hA, 1'b1, 1, -1, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
